// File: rtl/in_port_pkg.sv
// Shared types and sizing for the in_port CPU input peripheral.
package in_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    CONVERT,
    DONE
  } state_t;

  localparam int DEF_BCD_DIGITS = 4;
  localparam int BIN_WIDTH      = 4 * DEF_BCD_DIGITS;
  localparam int CNT_WIDTH      = $clog2(BIN_WIDTH + 1);

  // Width of a counter that must reach bin_w (one step per binary bit).
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Button synchronizer and debouncer; the debounced level resets high so a
// release must be seen before the first press can be accepted.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int L_CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_rise;
  logic            r_fall;
  logic [L_CW-1:0] r_count;

  logic w_differ;
  logic w_accept;

  // The Nth consecutive differing sample commits the new level.
  assign w_differ = (r_sync2 != r_level);
  assign w_accept = w_differ && (r_count == L_CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b1;
      r_count <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_rise  <= w_accept && r_sync2;
      r_fall  <= w_accept && !r_sync2;
      if (w_accept) begin
        r_level <= r_sync2;
        r_count <= '0;
      end else if (w_differ) begin
        r_count <= r_count + L_CW'(1);
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/in_port.sv
// CPU input peripheral: stalls an IN instruction until a debounced button
// press, then returns the BCD switch value converted to binary.
module in_port
  import in_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BCD_DIGITS      = DEF_BCD_DIGITS,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    button,
  input  logic                    read_enable,
  input  logic [4*BCD_DIGITS-1:0] switches,
  output logic [DATA_WIDTH-1:0]   read_value,
  output logic                    halt_from_input,
  output logic                    bcd_error
);

  localparam int L_BIN_W = 4 * BCD_DIGITS;
  localparam int L_CNT_W = cnt_width(L_BIN_W);

  state_t               r_state;
  logic [L_BIN_W-1:0]   r_bcd;
  logic [L_BIN_W-1:0]   r_bin;
  logic [L_CNT_W-1:0]   r_count;
  logic [DATA_WIDTH-1:0] r_read_value;
  logic                 r_bcd_error;

  state_t               w_state_next;
  logic                 w_level;
  logic                 w_rise;
  logic                 w_fall;
  logic [BCD_DIGITS-1:0] w_nib_bad;
  logic                 w_bad;
  logic [2*L_BIN_W-1:0] w_shift;
  logic [L_BIN_W-1:0]   w_shift_bcd;
  logic [L_BIN_W-1:0]   w_shift_bin;
  logic [L_BIN_W-1:0]   w_step_bcd;
  logic                 w_load;
  logic                 w_step;
  logic                 w_err_set;
  logic                 w_err_clr;
  logic                 w_finish;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_clock (clock),
    .i_reset (reset),
    .i_button(button),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Reverse double-dabble step: shift {bcd,bin} right, then pull any
  // digit that landed at 8 or above back by 3.
  assign w_shift     = {r_bcd, r_bin} >> 1;
  assign w_shift_bcd = w_shift[2*L_BIN_W-1:L_BIN_W];
  assign w_shift_bin = w_shift[L_BIN_W-1:0];

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    assign w_nib_bad[gi] = (switches[4*gi +: 4] > 4'd9);
    assign w_step_bcd[4*gi +: 4] = (w_shift_bcd[4*gi +: 4] >= 4'd8)
                                 ? (w_shift_bcd[4*gi +: 4] - 4'd3)
                                 : w_shift_bcd[4*gi +: 4];
  end

  assign w_bad = |w_nib_bad;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_enable) w_state_next = ARM;
      end
      ARM: begin
        // A release must be seen so a held button cannot satisfy two reads.
        if (!read_enable)              w_state_next = IDLE;
        else if (w_fall || !w_level)   w_state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!read_enable) begin
          w_state_next = IDLE;
        end else if (w_rise) begin
          w_load = 1'b1;
          if (w_bad) begin
            w_err_set    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_err_clr    = 1'b1;
            w_state_next = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (!read_enable) begin
          w_state_next = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == L_CNT_W'(L_BIN_W - 1)) begin
            w_finish     = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_count      <= '0;
      r_read_value <= '0;
      r_bcd_error  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_bcd   <= switches;
        r_bin   <= '0;
        r_count <= '0;
      end else if (w_step) begin
        r_bcd   <= w_step_bcd;
        r_bin   <= w_shift_bin;
        r_count <= r_count + L_CNT_W'(1);
      end
      if (w_err_set) begin
        r_read_value <= '0;
        r_bcd_error  <= 1'b1;
      end else if (w_err_clr) begin
        r_bcd_error  <= 1'b0;
      end
      if (w_finish) r_read_value <= DATA_WIDTH'(w_shift_bin);
    end
  end

  assign halt_from_input = read_enable && (r_state != DONE);
  assign read_value      = r_read_value;
  assign bcd_error       = r_bcd_error;

endmodule

// File: tb/tb_in_port.sv
// Self-checking bench for in_port: decimal reference model, random entries,
// glitch rejection, held-button back-to-back reads and mid-conversion reset.
module tb_in_port;

  logic        clock;
  logic        reset;
  logic        button;
  logic        read_enable;
  logic [15:0] switches;
  logic [31:0] read_value;
  logic        halt_from_input;
  logic        bcd_error;

  int total;
  int bad;

  localparam int SYNC_LAT  = 2;
  localparam int DEB       = 4;
  localparam int LAT_OK    = SYNC_LAT + DEB + 17;
  localparam int LAT_ERR   = SYNC_LAT + DEB + 1;

  in_port dut (
    .clock          (clock),
    .reset          (reset),
    .button         (button),
    .read_enable    (read_enable),
    .switches       (switches),
    .read_value     (read_value),
    .halt_from_input(halt_from_input),
    .bcd_error      (bcd_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: digits read as a decimal number; any digit above 9 is an error.
  function automatic void model(input logic [15:0] sw, output int val, output bit err);
    int d;
    val = 0;
    err = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(sw[4*i +: 4]);
      if (d > 9) err = 1'b1;
      val = val * 10 + d;
    end
    if (err) val = 0;
  endfunction

  // Press the button (released after `hold` cycles, 0 = keep held) and wait
  // for the single cycle in which halt drops.
  task automatic press_wait(input int hold, output int lat, output bit got);
    int c;
    got = 1'b0;
    lat = 0;
    c = 0;
    button = 1'b1;
    while (!got && c < 80) begin
      tick();
      c++;
      if (c == hold) button = 1'b0;
      if (c == LAT_ERR + 3) switches = 16'($urandom);
      if (!halt_from_input) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic run_read(input logic [15:0] sw, input string name);
    int  exp_val;
    bit  exp_err;
    int  lat;
    bit  got;
    model(sw, exp_val, exp_err);
    switches    = sw;
    read_enable = 1'b1;
    button      = 1'b0;
    repeat (8) tick();
    total++;
    if (halt_from_input !== 1'b1) begin
      bad++;
      $display("FAIL %s_halt_before: got %b want 1", name, halt_from_input);
    end
    press_wait(10, lat, got);
    button = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: got no DONE want DONE within 80 cycles", name);
      read_enable = 1'b0;
      repeat (12) tick();
      return;
    end
    $display("read %s sw=%h value=%0d err=%b lat=%0d", name, sw, read_value, bcd_error, lat);
    total++;
    if (lat != (exp_err ? LAT_ERR : LAT_OK)) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_err ? LAT_ERR : LAT_OK);
    end
    total++;
    if (read_value !== 32'(exp_val)) begin
      bad++;
      $display("FAIL %s_value: got %h want %h", name, read_value, 32'(exp_val));
    end
    total++;
    if (bcd_error !== exp_err) begin
      bad++;
      $display("FAIL %s_bcd_error: got %b want %b", name, bcd_error, exp_err);
    end
    tick();
    total++;
    if (halt_from_input !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_width: got halt %b want 1", name, halt_from_input);
    end
    read_enable = 1'b0;
    repeat (4) tick();
    total++;
    if (read_value !== 32'(exp_val)) begin
      bad++;
      $display("FAIL %s_hold: got %h want %h", name, read_value, 32'(exp_val));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; button = 1'b0; read_enable = 1'b0; switches = 16'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++;
    if (read_value !== 32'h0) begin
      bad++; $display("FAIL reset_value: got %h want 0", read_value);
    end
    total++;
    if (bcd_error !== 1'b0) begin
      bad++; $display("FAIL reset_bcd_error: got %b want 0", bcd_error);
    end
    total++;
    if (halt_from_input !== 1'b0) begin
      bad++; $display("FAIL reset_halt_idle: got %b want 0", halt_from_input);
    end
    read_enable = 1'b1;
    #1;
    total++;
    if (halt_from_input !== 1'b1) begin
      bad++; $display("FAIL reset_halt_req: got %b want 1", halt_from_input);
    end
    $display("reset checked value=%h err=%b", read_value, bcd_error);
  endtask

  task automatic test_basic();
    run_read(16'h1234, "basic1234");
    run_read(16'h9999, "basic9999");
    run_read(16'h12A4, "error12A4");
    run_read(16'h0005, "after_err0005");
    run_read(16'h0000, "basic0000");
  endtask

  task automatic test_glitch();
    int  widths [2] = '{2, 3};
    int  lat;
    bit  got;
    bit  dropped;
    switches    = 16'h0777;
    read_enable = 1'b1;
    button      = 1'b0;
    repeat (8) tick();
    foreach (widths[k]) begin
      dropped = 1'b0;
      button = 1'b1;
      repeat (widths[k]) begin
        tick();
        if (!halt_from_input) dropped = 1'b1;
      end
      button = 1'b0;
      repeat (30) begin
        tick();
        if (!halt_from_input) dropped = 1'b1;
      end
      total++;
      if (dropped) begin
        bad++; $display("FAIL glitch%0d: got halt dropped want halt held", widths[k]);
      end
      $display("glitch width=%0d halt_dropped=%b", widths[k], dropped);
    end
    press_wait(6, lat, got);
    button = 1'b0;
    total++;
    if (!got || read_value !== 32'd777) begin
      bad++; $display("FAIL glitch_accept: got done=%b value=%0d want done=1 value=777", got, read_value);
    end
    $display("pulse6 accepted done=%b value=%0d lat=%0d", got, read_value, lat);
    tick();
    read_enable = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int  lat;
    bit  got;
    int  dones;
    dones       = 0;
    switches    = 16'h0123;
    read_enable = 1'b1;
    button      = 1'b0;
    repeat (8) tick();
    press_wait(0, lat, got);
    if (got) dones++;
    total++;
    if (read_value !== 32'd123) begin
      bad++; $display("FAIL b2b_first: got %0d want 123", read_value);
    end
    repeat (40) begin
      tick();
      if (!halt_from_input) dones++;
    end
    button   = 1'b0;
    switches = 16'h0456;
    repeat (10) begin
      tick();
      if (!halt_from_input) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL b2b_held: got %0d DONE pulses want 1", dones);
    end
    press_wait(10, lat, got);
    button = 1'b0;
    if (got) dones++;
    total++;
    if (dones != 2 || read_value !== 32'd456) begin
      bad++; $display("FAIL b2b_second: got dones=%0d value=%0d want dones=2 value=456", dones, read_value);
    end
    $display("back_to_back dones=%0d value=%0d", dones, read_value);
    tick();
    read_enable = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    switches    = 16'h0321;
    read_enable = 1'b1;
    button      = 1'b0;
    repeat (8) tick();
    button = 1'b1;
    for (int c = 1; c <= SYNC_LAT + DEB + 1 + 8; c++) begin
      tick();
      if (c == 10) button = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (read_value !== 32'h0 || bcd_error !== 1'b0) begin
      bad++; $display("FAIL reset_mid_outputs: got value=%h err=%b want 0/0", read_value, bcd_error);
    end
    total++;
    if (halt_from_input !== 1'b1) begin
      bad++; $display("FAIL reset_mid_halt_hi: got %b want 1", halt_from_input);
    end
    read_enable = 1'b0;
    #1;
    total++;
    if (halt_from_input !== 1'b0) begin
      bad++; $display("FAIL reset_mid_halt_lo: got %b want 0", halt_from_input);
    end
    $display("reset mid-convert value=%h err=%b", read_value, bcd_error);
    run_read(16'h0042, "after_reset0042");
  endtask

  task automatic test_random();
    logic [15:0] sw;
    for (int n = 0; n < 12; n++) begin
      sw = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        for (int d = 0; d < 4; d++) sw[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run_read(sw, "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
